// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM block-transfer sequencer.
package arm_pkg;
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} seq_state_t;
    // Encoded as {p, u}
    typedef enum logic [1:0] {AM_DA = 2'b00, AM_IA = 2'b01, AM_DB = 2'b10, AM_IB = 2'b11} amode_t;
    localparam logic [3:0]  REG_PC     = 4'd15;
    localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/reg_list_enc.sv
// Register-list encoder: lowest set index, any-set flag and popcount.
module reg_list_enc (
    input  logic [15:0] mask,
    output logic [3:0]  first_idx,
    output logic        valid,
    output logic [4:0]  count
);
    always_comb begin
        first_idx = '0;
        count     = '0;
        for (int i = 15; i >= 0; i--)
            if (mask[i]) first_idx = 4'(i);
        for (int i = 0; i < 16; i++)
            count = count + 5'(mask[i]);
    end

    assign valid = |mask;
endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: one memory beat per listed register, ascending,
// followed by an optional base writeback.
module ldm_stm_seq
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        p_bit,
    input  logic        u_bit,
    input  logic        w_bit,
    input  logic [15:0] reg_list,
    input  logic [3:0]  rn,
    input  logic [31:0] base,
    output logic [3:0]  ra,
    input  logic [31:0] rd,
    output logic [3:0]  wa3,
    output logic [31:0] wd3,
    output logic        we3,
    output logic        pc_we,
    output logic [31:0] pc_wd,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done
);
    seq_state_t  state, nxt;
    logic [15:0] mask_q;
    logic [3:0]  rn_q;
    logic        load_q, wb_q;
    logic [31:0] addr_q, fbase_q;

    // One encoder: it sees the incoming list in IDLE and the remaining list while transferring.
    logic [15:0] enc_mask;
    logic [3:0]  cur_idx;
    logic        list_nz;
    logic [4:0]  cnt;

    assign enc_mask = (state == S_IDLE) ? reg_list : mask_q;

    reg_list_enc u_enc (
        .mask      (enc_mask),
        .first_idx (cur_idx),
        .valid     (list_nz),
        .count     (cnt)
    );

    logic [31:0] offset, start_addr, final_base;
    amode_t      amode;

    assign offset     = {25'd0, cnt, 2'b00};
    assign amode      = amode_t'({p_bit, u_bit});
    assign final_base = u_bit ? base + offset : base - offset;

    always_comb begin
        case (amode)
            AM_IA:   start_addr = base;
            AM_IB:   start_addr = base + WORD_BYTES;
            AM_DA:   start_addr = base - offset + WORD_BYTES;
            default: start_addr = base - offset;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (start) nxt = list_nz ? S_XFER : S_DONE;
            S_XFER: if (mem_ready && cnt == 5'd1) nxt = wb_q ? S_WB : S_DONE;
            S_WB:   nxt = S_DONE;
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_q  <= '0;
            rn_q    <= '0;
            load_q  <= 1'b0;
            wb_q    <= 1'b0;
            addr_q  <= '0;
            fbase_q <= '0;
        end else if (state == S_IDLE && start) begin
            mask_q  <= reg_list;
            rn_q    <= rn;
            load_q  <= is_load;
            // A load that includes the base register keeps the loaded value.
            wb_q    <= w_bit & ~(is_load & reg_list[rn]);
            addr_q  <= start_addr;
            fbase_q <= final_base;
        end else if (state == S_XFER && mem_ready) begin
            mask_q  <= mask_q & ~(16'd1 << cur_idx);
            addr_q  <= addr_q + WORD_BYTES;
        end
    end

    always_comb begin
        ra       = '0;
        wa3      = '0;
        wd3      = '0;
        we3      = 1'b0;
        pc_we    = 1'b0;
        pc_wd    = '0;
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_wd   = '0;
        mem_req  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = addr_q;
                mem_we   = !load_q;
                if (!load_q) begin
                    ra     = cur_idx;
                    mem_wd = rd;
                end else if (cur_idx == REG_PC) begin
                    pc_we = mem_ready;
                    pc_wd = mem_rdata & ~32'd3;
                end else begin
                    we3 = mem_ready;
                    wa3 = cur_idx;
                    wd3 = mem_rdata;
                end
            end
            S_WB: begin
                busy = 1'b1;
                we3  = 1'b1;
                wa3  = rn_q;
                wd3  = fbase_q;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq with a register-file/memory model and event scoreboard.
module tb_ldm_stm_seq;
    logic        clk = 1'b0;
    logic        reset, start, is_load, p_bit, u_bit, w_bit;
    logic [15:0] reg_list;
    logic [3:0]  rn, ra, wa3;
    logic [31:0] base, rd, wd3, pc_wd, mem_addr, mem_wd, mem_rdata;
    logic        we3, pc_we, mem_we, mem_req, mem_ready, busy, done;

    typedef struct packed {
        logic [1:0]  kind;   // 1 store, 2 reg write, 3 pc load
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t         exp_q[$];
    int          n_vec = 0, n_err = 0;
    logic [31:0] rf  [0:15];
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    ldm_stm_seq dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load),
        .p_bit(p_bit), .u_bit(u_bit), .w_bit(w_bit), .reg_list(reg_list),
        .rn(rn), .base(base), .ra(ra), .rd(rd), .wa3(wa3), .wd3(wd3),
        .we3(we3), .pc_we(pc_we), .pc_wd(pc_wd), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wd(mem_wd), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done)
    );

    assign rd        = (ra == 4'd15) ? 32'h0000_8008 : rf[ra];
    assign mem_rdata = mem[mem_addr[9:2]];

    // Register file model; reset preloads R0=A, R2=B, R4=C, others 0x100+i.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'h100 + 32'(i);
            rf[0] <= 32'hA;
            rf[2] <= 32'hB;
            rf[4] <= 32'hC;
        end else if (we3) begin
            rf[wa3] <= wd3;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic observe(input ev_t ev);
        ev_t e;
        if (exp_q.size() == 0) chk("unexpected_event", 96'(ev), 96'd0);
        else begin
            e = exp_q.pop_front();
            chk("event", 96'(ev), 96'(e));
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (mem_req && mem_we && mem_ready) observe('{2'd1, mem_addr, mem_wd});
            if (we3)   observe('{2'd2, {28'd0, wa3}, wd3});
            if (pc_we) observe('{3, 32'd0, pc_wd});
        end
    end

    task automatic chk_idle(input string tag);
        chk(tag, 96'({busy, done, mem_req, mem_we, we3, pc_we, ra, wa3, wd3,
                      mem_addr, mem_wd, pc_wd} != '0), 96'd0);
    endtask

    task automatic drive(input logic l, input logic p, input logic u, input logic w,
                         input logic [15:0] list, input logic [3:0] r, input logic [31:0] b);
        is_load = l; p_bit = p; u_bit = u; w_bit = w;
        reg_list = list; rn = r; base = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Cycles from the accepting edge to the cycle that shows done (-1 on timeout).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    function automatic ev_t st(input logic [31:0] a, input logic [31:0] d);
        return '{2'd1, a, d};
    endfunction
    function automatic ev_t wr(input logic [3:0] r, input logic [31:0] d);
        return '{2'd2, {28'd0, r}, d};
    endfunction

    initial begin
        int lat;
        logic [31:0] exp_addr [1:5];
        reset = 1'b0; start = 1'b0; is_load = 1'b0; p_bit = 1'b0; u_bit = 1'b0;
        w_bit = 1'b0; reg_list = '0; rn = '0; base = '0; mem_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        mem[8'h7E] = 32'h11;        // 0x1F8
        mem[8'h7F] = 32'h22;        // 0x1FC
        mem[8'hC0] = 32'h33;        // 0x300
        mem[8'hC1] = 32'h44;        // 0x304
        mem[8'hC4] = 32'h0000_1003; // 0x310

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_idle("reset_outputs");
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("idle_after_reset");
        @(posedge clk); #1;

        // STM IA, no writeback
        exp_q.push_back(st(32'h100, 32'hA));
        exp_q.push_back(st(32'h104, 32'hB));
        exp_q.push_back(st(32'h108, 32'hC));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0015, 4'd3, 32'h100);
        wait_done(lat);
        chk("stm_ia_latency", 96'(lat), 96'd4);
        chk("stm_ia_drained", 96'(exp_q.size()), 96'd0);

        // LDM DB with writeback
        exp_q.push_back(wr(4'd6, 32'h11));
        exp_q.push_back(wr(4'd7, 32'h22));
        exp_q.push_back(wr(4'd1, 32'h1F8));
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h00C0, 4'd1, 32'h200);
        wait_done(lat);
        chk("ldm_db_latency", 96'(lat), 96'd4);
        chk("ldm_db_drained", 96'(exp_q.size()), 96'd0);

        // LDM IA with writeback, base register in list: no WB cycle
        exp_q.push_back(wr(4'd1, 32'h33));
        exp_q.push_back(wr(4'd2, 32'h44));
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0006, 4'd2, 32'h300);
        wait_done(lat);
        chk("ldm_rn_latency", 96'(lat), 96'd3);
        chk("ldm_rn_drained", 96'(exp_q.size()), 96'd0);
        chk("ldm_rn_r2", 96'(rf[2]), 96'h44);

        // LDM of R15 loads the PC, word-aligned
        exp_q.push_back('{2'd3, 32'd0, 32'h0000_1000});
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 4'd0, 32'h310);
        wait_done(lat);
        chk("ldm_pc_latency", 96'(lat), 96'd2);
        chk("ldm_pc_drained", 96'(exp_q.size()), 96'd0);

        // STM IA with two wait cycles on the second beat
        exp_q.push_back(st(32'h120, 32'h108));
        exp_q.push_back(st(32'h124, 32'h109));
        exp_q.push_back(st(32'h128, 32'h10A));
        exp_addr[1] = 32'h120; exp_addr[2] = 32'h124; exp_addr[3] = 32'h124;
        exp_addr[4] = 32'h124; exp_addr[5] = 32'h128;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0700, 4'd0, 32'h120);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 5) chk("wait_addr", 96'({mem_req, done, mem_addr}), 96'({1'b1, 1'b0, exp_addr[c]}));
            else        chk("wait_done", 96'({mem_req, done}), 96'({1'b0, 1'b1}));
            @(posedge clk); #1;
            mem_ready = (c + 1 == 2 || c + 1 == 3) ? 1'b0 : 1'b1;
        end
        mem_ready = 1'b1;
        chk("wait_drained", 96'(exp_q.size()), 96'd0);

        // Empty list: done next cycle, nothing else
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 4'd0, 32'h500);
        @(negedge clk);
        chk("empty_done", 96'({done, busy, mem_req, we3}), 96'({1'b1, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("empty_back_idle");
        @(posedge clk); #1;

        // Reset during beat 2 of 4 aborts the transfer
        exp_q.push_back(st(32'h140, 32'h108));
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0F00, 4'd5, 32'h140);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_beat2", 96'({mem_req, mem_addr}), 96'({1'b1, 32'h144}));
        @(posedge clk); #1;
        reset = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle("abort_idle");
            @(posedge clk); #1;
        end
        chk("abort_drained", 96'(exp_q.size()), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ldm_stm_seq.md
# ldm_stm_seq

Multi-cycle sequencer for ARM block-transfer instructions (LDM/STM). It walks a 16-bit register list in ascending order and drives the register file's read port (STM) or write port (LDM), one data-memory beat per register. It then optionally writes back the updated base register. It sits between the datapath's register file and data memory and stalls the core through `busy` while a transfer is in progress.

## Interface
Parameters:
- none. Width is fixed at 32-bit data and 4-bit register addresses.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request, sampled only in IDLE.
- `is_load` in 1: 1 = LDM, 0 = STM.
- `p_bit`, `u_bit`, `w_bit` in 1 each: pre-index, up, and base-writeback flags.
- `reg_list` in 16: transfer mask; bit i selects Ri.
- `rn` in 4: base register number.
- `base` in 32: base register value, sampled with `start`.
- `ra` out 4: register-file read address, for STM.
- `rd` in 32: register-file read data. The register file returns PC+8 for R15.
- `wa3` out 4, `wd3` out 32, `we3` out 1: register-file write port.
- `pc_we` out 1, `pc_wd` out 32: PC load, used when an LDM list includes R15.
- `mem_addr` out 32, `mem_we` out 1, `mem_wd` out 32, `mem_req` out 1: data-memory request.
- `mem_rdata` in 32, `mem_ready` in 1: memory response.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, XFER, WB, DONE.
- **IDLE → XFER** on `start` when `reg_list` is nonzero. The sequencer latches `reg_list`, `rn`, `is_load`, `w_bit`, `u_bit`, the computed start address, and the final base value.
- **IDLE → DONE** on `start` when `reg_list` is zero. No memory or register activity and no writeback take place.
- Count and offset: n = popcount(`reg_list`), 0..16; offset = 4·n, 32-bit unsigned.
- Start address by mode:
  - IA (P=0, U=1): base.
  - IB (P=1, U=1): base+4.
  - DA (P=0, U=0): base−offset+4.
  - DB (P=1, U=0): base−offset.
- Final base: U ? base+offset : base−offset. All arithmetic is mod 2^32.
- **XFER beat** (current register = lowest set bit of the remaining mask):
  - The sequencer holds `mem_req`=1, `mem_addr`, and `mem_we`=!`is_load`.
  - STM: `ra` = current register and `mem_wd` = `rd`.
  - On a rising edge with `mem_ready`=1 the beat completes: its mask bit clears and the address advances by 4.
  - LDM: in the completing cycle, `we3`=1, `wa3` = current register, `wd3` = `mem_rdata`.
  - LDM with R15: `pc_we`=1 and `pc_wd` = `mem_rdata` & ~3, with `we3`=0.
- **After the last beat:**
  - Go to WB if `w_bit`, except on an LDM whose list contains `rn`. In that case the loaded value wins and the state goes straight to DONE.
  - Otherwise go to DONE.
- **WB:** one cycle with `we3`=1, `wa3`=`rn`, `wd3` = final base, then DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `start` is ignored while not in IDLE.

## Timing
- Reset values: state=IDLE. All outputs are 0: `busy`, `done`, `mem_req`, `mem_we`, `we3`, `pc_we`, `ra`, `wa3`, `wd3`, `mem_addr`, `mem_wd`, `pc_wd`.
- Reset asserted mid-transfer aborts on that edge. Beats not yet completed are dropped, and no writeback or `done` is issued.
- Latency with zero wait states (`mem_ready` tied high): n beats + (1 if WB) + 1 DONE cycle after the `start` edge.
  - Example: 3 registers with writeback gives `done` in the 5th cycle after `start`.
- Each beat lasts 1 + (wait cycles) cycles. Outputs stay stable while `mem_ready`=0.
- `we3` and `pc_we` are combinational with `mem_ready` in the completing cycle only. They are never high in a stalled cycle.
- Empty list: `done` in the cycle after `start`; `busy` stays low.

## Structure
- Shared package `arm_pkg`:
  - `seq_state_t` enum for the four states.
  - `amode_t` enum for IA/IB/DA/DB.
  - Constant `REG_PC` = 4'd15.
  - Constant `WORD_BYTES` = 4.
- Sub-module `reg_list_enc`, purely combinational:
  - Input: 16-bit mask.
  - Outputs: `first_idx`[3:0], `valid`, and `count`[4:0].
  - Used both at `start` (count) and per beat (first index).

## Test plan
- **STM IA, no W.** base=0x100, list=0x0015 (R0, R2, R4), R0=0xA, R2=0xB, R4=0xC, `mem_ready`=1 → stores at 0x100/0x104/0x108 with data 0xA/0xB/0xC; `done` in the 4th cycle after `start`; no `we3`.
- **LDM DB with W.** base=0x200, rn=1, list=0x00C0 (R6, R7), memory 0x1F8=0x11, 0x1FC=0x22 → R6=0x11, R7=0x22, then R1=0x1F8.
- **LDM IA with W, rn=2 in list.** list=0x0006 → R1 and R2 loaded from memory; no WB cycle; R2 holds the loaded value.
- **LDM with R15.** list=0x8000, memory word=0x0000_1003 → `pc_we`=1 with `pc_wd`=0x0000_1000; `we3` stays 0.
- **Wait states.** `mem_ready` low for 2 cycles on the second beat of a 3-register STM → `mem_addr` is held; `done` arrives 2 cycles later than with no waits.
- **Edge cases.** Empty list → `done` next cycle with no `mem_req`. Reset low during beat 2 of 4 → all outputs 0 next cycle, IDLE, no `done`.
